// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds data/address widths, fixed destination registers, requester indices,
// starvation limit, scheduler state encoding and the compare-flag helper.
package rf_write_scheduler_pkg;

    localparam int WORD_LEN = 32;
    localparam int ADDR_LEN = 4;
    localparam int IMM_LEN  = 12;

    localparam logic [ADDR_LEN-1:0] LO_REG   = 4'd13;
    localparam logic [ADDR_LEN-1:0] HI_REG   = 4'd12;
    localparam logic [ADDR_LEN-1:0] FLAG_REG = 4'd9;

    // Requester indices; lower index means higher fixed priority.
    localparam int NUM_REQ = 4;
    localparam int REQ_MUL = 0;
    localparam int REQ_WB  = 1;
    localparam int REQ_MOV = 2;
    localparam int REQ_CMP = 3;

    localparam int                WAIT_W     = 3;
    localparam logic [WAIT_W-1:0] STARVE_LIM = 3'd4;

    localparam logic [WORD_LEN-1:0] MASK_ALL  = {WORD_LEN{1'b1}};
    localparam logic [WORD_LEN-1:0] MASK_FLAG = 32'h0000_0003;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_MUL_HI = 1'b1
    } sched_state_t;

    // Flag word: bit0 = Z (result is zero), bit1 = N (result negative).
    function automatic logic [WORD_LEN-1:0] cmp_flags(input logic [WORD_LEN-1:0] result);
        logic [WORD_LEN-1:0] f;
        f    = '0;
        f[0] = (result == '0);
        f[1] = result[WORD_LEN-1];
        return f;
    endfunction

endpackage

// File: rtl/rf_prio_arbiter.sv
// 4-way fixed-priority arbiter with starvation override.
// Ports: clk, rst (sync, active-high), i_valid (request vector), i_en (arbitration
// allowed), o_grant (one-hot, combinational). Keeps one saturating wait counter per requester.
module rf_prio_arbiter
    import rf_write_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [WAIT_W-1:0]  r_wait [NUM_REQ];
    logic [NUM_REQ-1:0] w_starved;
    logic [NUM_REQ-1:0] w_pool;
    logic [NUM_REQ-1:0] w_pick;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starved[i] = i_valid[i] && (r_wait[i] == STARVE_LIM);
        end
        // Starved requesters form the candidate pool if there are any; the
        // same fixed order then breaks ties among them.
        w_pool  = (|w_starved) ? w_starved : i_valid;
        // Isolate lowest set bit = highest-priority candidate.
        w_pick  = w_pool & (~w_pool + NUM_REQ'(1));
        o_grant = i_en ? w_pick : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!i_valid[i] || o_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != STARVE_LIM) begin
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Single-write-port scheduler serialising WB, MUL (two beats), MOV and CMP into the register file.
// Ports: four valid/ready requesters in, one registered write (rf_we/addr/wdata/wmask) out,
// stall out. Write latency one cycle; readys are combinational, all low in MUL_HI and reset.
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0] wb_data,
    output logic                wb_ready,
    input  logic                mul_valid,
    input  logic [WORD_LEN-1:0] mul_lo,
    input  logic [WORD_LEN-1:0] mul_hi,
    output logic                mul_ready,
    input  logic                mov_valid,
    input  logic [ADDR_LEN-1:0] mov_dest,
    input  logic [IMM_LEN-1:0]  mov_imm,
    output logic                mov_ready,
    input  logic                cmp_valid,
    input  logic [WORD_LEN-1:0] cmp_result,
    output logic                cmp_ready,
    output logic                rf_we,
    output logic [ADDR_LEN-1:0] rf_addr,
    output logic [WORD_LEN-1:0] rf_wdata,
    output logic [WORD_LEN-1:0] rf_wmask,
    output logic                stall
);

    sched_state_t        r_state;
    logic [WORD_LEN-1:0] r_hold;
    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [WORD_LEN-1:0] r_wmask;

    logic [NUM_REQ-1:0]  w_valid;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_en;

    always_comb begin
        w_valid          = '0;
        w_valid[REQ_MUL] = mul_valid;
        w_valid[REQ_WB]  = wb_valid;
        w_valid[REQ_MOV] = mov_valid;
        w_valid[REQ_CMP] = cmp_valid;
        // Gating with rst keeps every ready low while reset is held.
        w_en             = (r_state == ST_ISSUE) && !rst;
    end

    rf_prio_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_valid),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    assign mul_ready = w_grant[REQ_MUL];
    assign wb_ready  = w_grant[REQ_WB];
    assign mov_ready = w_grant[REQ_MOV];
    assign cmp_ready = w_grant[REQ_CMP];
    assign stall     = |(w_valid & ~w_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ISSUE;
            r_hold  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            case (r_state)
                ST_MUL_HI: begin
                    r_we    <= 1'b1;
                    r_addr  <= HI_REG;
                    r_wdata <= r_hold;
                    r_wmask <= MASK_ALL;
                    r_state <= ST_ISSUE;
                end
                default: begin
                    if (w_grant[REQ_MUL]) begin
                        r_we    <= 1'b1;
                        r_addr  <= LO_REG;
                        r_wdata <= mul_lo;
                        r_wmask <= MASK_ALL;
                        r_hold  <= mul_hi;
                        r_state <= ST_MUL_HI;
                    end else if (w_grant[REQ_WB]) begin
                        // Writes to r0 complete the handshake but are suppressed.
                        r_we    <= (wb_dest != '0);
                        r_addr  <= wb_dest;
                        r_wdata <= wb_data;
                        r_wmask <= MASK_ALL;
                    end else if (w_grant[REQ_MOV]) begin
                        r_we    <= (mov_dest != '0);
                        r_addr  <= mov_dest;
                        r_wdata <= {{(WORD_LEN-IMM_LEN){1'b0}}, mov_imm};
                        r_wmask <= MASK_ALL;
                    end else if (w_grant[REQ_CMP]) begin
                        r_we    <= 1'b1;
                        r_addr  <= FLAG_REG;
                        r_wdata <= cmp_flags(cmp_result);
                        r_wmask <= MASK_FLAG;
                    end else begin
                        // No transfer: drop enable, keep address/data/mask.
                        r_we    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rf_we    = r_we;
    assign rf_addr  = r_addr;
    assign rf_wdata = r_wdata;
    assign rf_wmask = r_wmask;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a write scoreboard.
// Each step pushes the expected register-file write, checks readys/stall mid-cycle,
// then pops and compares the registered write after the clock edge.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        mul_valid;
    logic [31:0] mul_lo;
    logic [31:0] mul_hi;
    logic        mul_ready;
    logic        mov_valid;
    logic [3:0]  mov_dest;
    logic [11:0] mov_imm;
    logic        mov_ready;
    logic        cmp_valid;
    logic [31:0] cmp_result;
    logic        cmp_ready;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_wmask;
    logic        stall;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic        full;   // 0: only rf_we is compared
    } wr_t;

    wr_t wr_q[$];

    always #5 clk = ~clk;

    rf_write_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .mul_valid  (mul_valid),
        .mul_lo     (mul_lo),
        .mul_hi     (mul_hi),
        .mul_ready  (mul_ready),
        .mov_valid  (mov_valid),
        .mov_dest   (mov_dest),
        .mov_imm    (mov_imm),
        .mov_ready  (mov_ready),
        .cmp_valid  (cmp_valid),
        .cmp_result (cmp_result),
        .cmp_ready  (cmp_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rf_wmask   (rf_wmask),
        .stall      (stall)
    );

    task automatic push_wr(input logic we, input logic [3:0] addr,
                           input logic [31:0] data, input logic [31:0] mask);
        wr_t w;
        w.we = we; w.addr = addr; w.data = data; w.mask = mask; w.full = 1'b1;
        wr_q.push_back(w);
    endtask

    task automatic push_nowr();
        wr_t w;
        w = '0;
        wr_q.push_back(w);
    endtask

    // Inputs are already driven; check readys {cmp,mov,wb,mul} and stall,
    // advance one clock, then compare the registered write against the scoreboard.
    task automatic step(input logic [3:0] exp_rdy, input logic exp_stall, input string tag);
        logic [3:0] rdy;
        wr_t        w;
        #1;
        rdy = {cmp_ready, mov_ready, wb_ready, mul_ready};
        checks++;
        assert (rdy === exp_rdy) else begin
            errors++;
            $error("FAIL %s ready: observed %b expected %b", tag, rdy, exp_rdy);
        end
        checks++;
        assert (stall === exp_stall) else begin
            errors++;
            $error("FAIL %s stall: observed %b expected %b", tag, stall, exp_stall);
        end
        @(posedge clk);
        #2;
        if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed empty queue expected one entry", tag);
        end else begin
            w = wr_q.pop_front();
            checks++;
            assert (rf_we === w.we) else begin
                errors++;
                $error("FAIL %s rf_we: observed %b expected %b", tag, rf_we, w.we);
            end
            if (w.full) begin
                checks++;
                assert ({rf_addr, rf_wdata, rf_wmask} === {w.addr, w.data, w.mask}) else begin
                    errors++;
                    $error("FAIL %s write: observed addr=%0d data=%h mask=%h expected addr=%0d data=%h mask=%h",
                           tag, rf_addr, rf_wdata, rf_wmask, w.addr, w.data, w.mask);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
        mul_valid = 1'b0; mul_lo = '0; mul_hi = '0;
        mov_valid = 1'b0; mov_dest = '0; mov_imm = '0;
        cmp_valid = 1'b0; cmp_result = '0;
        @(posedge clk);
        #2;

        // Reset: a valid request must see no ready; outputs are zero.
        wb_valid = 1'b1; wb_dest = 4'd5; wb_data = 32'hDEAD_BEEF;
        push_wr(1'b0, 4'd0, 32'h0, 32'h0);
        step(4'b0000, 1'b1, "reset");

        // Plain writeback, one-cycle latency.
        rst = 1'b0;
        push_wr(1'b1, 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        step(4'b0010, 1'b0, "wb_basic");

        // MUL beats r13 then r12 while WB waits two cycles.
        mul_valid = 1'b1; mul_lo = 32'h11; mul_hi = 32'h22;
        wb_valid = 1'b1; wb_dest = 4'd6; wb_data = 32'h0000_0066;
        push_wr(1'b1, 4'd13, 32'h11, 32'hFFFF_FFFF);
        step(4'b0001, 1'b1, "mul_lo");
        mul_valid = 1'b0; mul_lo = '0; mul_hi = '0;
        push_wr(1'b1, 4'd12, 32'h22, 32'hFFFF_FFFF);
        step(4'b0000, 1'b1, "mul_hi");
        push_wr(1'b1, 4'd6, 32'h0000_0066, 32'hFFFF_FFFF);
        step(4'b0010, 1'b0, "wb_after_mul");
        wb_valid = 1'b0;

        // Compare flags: zero, negative, positive.
        cmp_valid = 1'b1; cmp_result = 32'd0;
        push_wr(1'b1, 4'd9, 32'h1, 32'h3);
        step(4'b1000, 1'b0, "cmp_zero");
        cmp_result = -32'sd7;
        push_wr(1'b1, 4'd9, 32'h2, 32'h3);
        step(4'b1000, 1'b0, "cmp_neg");
        cmp_result = 32'd3;
        push_wr(1'b1, 4'd9, 32'h0, 32'h3);
        step(4'b1000, 1'b0, "cmp_pos");
        cmp_valid = 1'b0;

        // Idle cycle: enable drops, address/data/mask hold.
        push_wr(1'b0, 4'd9, 32'h0, 32'h3);
        step(4'b0000, 1'b0, "idle_hold");

        // MOV to r0 is accepted but suppressed; MOV to r3 writes.
        mov_valid = 1'b1; mov_dest = 4'd0; mov_imm = 12'hABC;
        push_nowr();
        step(4'b0100, 1'b0, "mov_r0");
        mov_dest = 4'd3;
        push_wr(1'b1, 4'd3, 32'h0000_0ABC, 32'hFFFF_FFFF);
        step(4'b0100, 1'b0, "mov_r3");
        mov_valid = 1'b0;

        // Starvation: CMP waits behind a continuous WB stream and is
        // promoted once its counter reaches 4 (fifth cycle).
        cmp_valid = 1'b1; cmp_result = 32'hFFFF_FFFF;
        wb_valid = 1'b1; wb_dest = 4'd7;
        for (int i = 0; i < 4; i++) begin
            wb_data = 32'h100 + i;
            push_wr(1'b1, 4'd7, 32'h100 + i, 32'hFFFF_FFFF);
            step(4'b0010, 1'b1, $sformatf("starve_wb%0d", i));
        end
        wb_data = 32'h200;
        push_wr(1'b1, 4'd9, 32'h2, 32'h3);
        step(4'b1000, 1'b1, "starve_cmp");
        cmp_valid = 1'b0;
        push_wr(1'b1, 4'd7, 32'h200, 32'hFFFF_FFFF);
        step(4'b0010, 1'b0, "starve_wb_resume");
        wb_valid = 1'b0;

        // Reset during MUL_HI abandons the r12 write.
        mul_valid = 1'b1; mul_lo = 32'h33; mul_hi = 32'h44;
        push_wr(1'b1, 4'd13, 32'h33, 32'hFFFF_FFFF);
        step(4'b0001, 1'b0, "mul2_lo");
        mul_valid = 1'b0;
        rst = 1'b1;
        push_wr(1'b0, 4'd0, 32'h0, 32'h0);
        step(4'b0000, 1'b0, "rst_in_mul_hi");
        rst = 1'b0;
        push_wr(1'b0, 4'd0, 32'h0, 32'h0);
        step(4'b0000, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
